// File: rtl/riscv_pkg.sv
// riscv_pkg: access-size encodings, memory FSM states and bus-lane helpers
//   LEN_BYTE/LEN_HALF/LEN_WORD : encodings of the 2-bit length field (11 reserved)
//   state_t                    : IDLE / ACCESS / DONE
//   is_legal, byte_en, lane_rep: alignment test, byte enables, store-lane replication
package riscv_pkg;

    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b10;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    function automatic logic is_legal(input logic [1:0] len, input logic [1:0] off);
        return (len == LEN_BYTE) || (len == LEN_HALF && !off[0]) || (len == LEN_WORD && off == 2'b00);
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] len, input logic [1:0] off);
        return len == LEN_BYTE ? 4'b0001 << off :
               len == LEN_HALF ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction

    function automatic logic [31:0] lane_rep(input logic [1:0] len, input logic [31:0] wd);
        return len == LEN_BYTE ? {4{wd[7:0]}} :
               len == LEN_HALF ? {2{wd[15:0]}} : wd;
    endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend: picks the addressed lane out of a read word and sign/zero-extends it
//   word   in  32 : raw word from memory
//   offset in  2  : byte offset within the word
//   length in  2  : access size (byte/half/word)
//   sign   in  1  : 1 sign-extends, 0 zero-extends
//   result out 32 : extended load value
module load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  length,
    input  logic        sign,
    output logic [31:0] result
);

    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;

    assign shifted = word >> {offset, 3'b000};
    assign b       = shifted[7:0];
    assign h       = offset[1] ? word[31:16] : word[15:0];
    assign result  = length == LEN_BYTE ? {{24{sign & b[7]}}, b} :
                     length == LEN_HALF ? {{16{sign & h[15]}}, h} : word;

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer between the pipeline and a data-memory bus
//   pipeline side : memread, memwrite, length, sign, addr, wdata in; rdata, stall, misalign out
//   bus side      : dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata out; dmem_rdata, dmem_ack in
//   clk / rst     : single clock, asynchronous active-high reset
module mem_access_unit
    import riscv_pkg::*;
#(
    parameter int DMEM_AW = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               memread,
    input  logic               memwrite,
    input  logic [1:0]         length,
    input  logic               sign,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [3:0]         dmem_be,
    output logic [31:0]        dmem_wdata,
    input  logic [31:0]        dmem_rdata,
    input  logic               dmem_ack,
    output logic [31:0]        rdata,
    output logic               stall,
    output logic               misalign
);

    state_t             state_q, state_d;
    logic               we_q, we_d, sign_q, sign_d;
    logic [DMEM_AW-1:0] addr_q, addr_d;
    logic [3:0]         be_q, be_d;
    logic [31:0]        wdata_q, wdata_d, rdata_q, rdata_d, ext;
    logic [1:0]         len_q, len_d, off_q, off_d;
    logic               req, legal, unused_hi;

    assign req       = memread | memwrite;
    assign legal     = is_legal(length, addr[1:0]);
    assign unused_hi = ^addr[31:DMEM_AW];

    load_extend u_ext (
        .word   (dmem_rdata),
        .offset (off_q),
        .length (len_q),
        .sign   (sign_q),
        .result (ext)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        sign_d  = sign_q;
        len_d   = len_q;
        off_d   = off_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (req && legal) begin
                state_d = ACCESS;
                we_d    = memwrite;
                addr_d  = {addr[DMEM_AW-1:2], 2'b00};
                be_d    = byte_en(length, addr[1:0]);
                wdata_d = lane_rep(length, wdata);
                sign_d  = sign;
                len_d   = length;
                off_d   = addr[1:0];
            end
            ACCESS: if (dmem_ack) begin
                state_d = DONE;
                rdata_d = we_q ? rdata_q : ext;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            sign_q  <= 1'b0;
            len_q   <= LEN_BYTE;
            off_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            sign_q  <= sign_d;
            len_q   <= len_d;
            off_q   <= off_d;
            rdata_q <= rdata_d;
        end
    end

    // The IDLE-cycle stall and misalign are combinational from the inputs, so they are
    // gated by rst to read 0 during reset even while a request is still presented.
    assign dmem_req   = state_q == ACCESS;
    assign stall      = !rst && (state_q == ACCESS || (state_q == IDLE && req && legal));
    assign misalign   = !rst && state_q == IDLE && req && !legal;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;
    assign rdata      = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized checks of mem_access_unit against a size/offset model
module tb_mem_access_unit;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst, memread, memwrite, sign, dmem_req, dmem_we, dmem_ack, stall, misalign;
    logic [1:0]    length;
    logic [31:0]   addr, wdata, dmem_wdata, dmem_rdata, rdata;
    logic [AW-1:0] dmem_addr;
    logic [3:0]    dmem_be;

    int          n_checks = 0;
    int          n_fail = 0;
    int          stall_cnt = 0;
    int          req_rises = 0;
    logic        req_prev = 1'b0;
    logic [31:0] exp_rdata = '0;

    mem_access_unit #(.DMEM_AW(AW)) dut (
        .clk(clk), .rst(rst), .memread(memread), .memwrite(memwrite), .length(length),
        .sign(sign), .addr(addr), .wdata(wdata), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .rdata(rdata), .stall(stall),
        .misalign(misalign)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (stall) stall_cnt++;
        if (dmem_req && !req_prev) req_rises++;
        req_prev = dmem_req;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int size_of(input logic [1:0] len);
        return 1 << len;
    endfunction

    function automatic bit m_legal(input logic [1:0] len, input logic [31:0] a);
        return len != 2'b11 && (a % size_of(len)) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] len, input logic [31:0] a);
        logic [3:0] be = '0;
        int off = int'(a % 4);
        for (int i = 0; i < 4; i++) if (i >= off && i < off + size_of(len)) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] len, input logic [31:0] wd);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % size_of(len)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_ld(input logic [1:0] len, input bit sgn, input logic [31:0] a, input logic [31:0] w);
        int sz = size_of(len);
        logic [31:0] mask = sz == 4 ? 32'hFFFF_FFFF : (32'h1 << (8*sz)) - 1;
        logic [31:0] v = (w >> (8 * (a % 4))) & mask;
        if (sgn && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic drop();
        memread = 0; memwrite = 0; length = 0; sign = 0; addr = 0; wdata = 0;
    endtask

    // Entered and left 1 time unit after a rising edge, in the cycle the request is presented.
    task automatic do_access(input bit rd, input bit wr, input logic [1:0] len, input bit sgn,
                             input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rword,
                             input int dly, input bit keep);
        bit ok = m_legal(len, a);
        memread = rd; memwrite = wr; length = len; sign = sgn; addr = a; wdata = wd;
        @(negedge clk);
        check("stall_idle", 32'(stall), 32'(ok));
        check("misalign", 32'(misalign), 32'(!ok));
        check("req_idle", 32'(dmem_req), 0);
        if (!ok) begin
            @(posedge clk); #1;
            drop();
            @(negedge clk);
            check("misalign_drop", 32'(misalign), 0);
            check("req_after_mis", 32'(dmem_req), 0);
            check("rdata_mis", rdata, exp_rdata);
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        for (int i = 0; i <= dly; i++) begin
            dmem_ack = (i == dly);
            dmem_rdata = (i == dly) ? rword : $urandom;
            @(negedge clk);
            check("req_access", 32'(dmem_req), 1);
            check("stall_access", 32'(stall), 1);
            check("we", 32'(dmem_we), 32'(wr));
            check("addr", 32'(dmem_addr), a & ((32'h1 << AW) - 1) & ~32'h3);
            check("be", 32'(dmem_be), 32'(m_be(len, a)));
            if (wr) check("wdata", dmem_wdata, m_wd(len, wd));
            @(posedge clk); #1;
        end
        if (!wr) exp_rdata = m_ld(len, sgn, a, rword);
        dmem_ack = 0;
        if (!keep) drop();
        @(negedge clk);
        check("stall_done", 32'(stall), 0);
        check("req_done", 32'(dmem_req), 0);
        check("rdata", rdata, exp_rdata);
        @(posedge clk); #1;
    endtask

    initial begin
        int r0;
        rst = 1; dmem_ack = 0; dmem_rdata = 0;
        drop();
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(dmem_req), 0);
        check("rst_stall", 32'(stall), 0);
        check("rst_mis", 32'(misalign), 0);
        check("rst_we", 32'(dmem_we), 0);
        check("rst_be", 32'(dmem_be), 0);
        check("rst_addr", 32'(dmem_addr), 0);
        check("rst_wdata", dmem_wdata, 0);
        check("rst_rdata", rdata, 0);
        rst = 0;
        @(posedge clk); #1;

        stall_cnt = 0;
        do_access(1, 0, 2'b10, 0, 32'h104, 0, 32'hDEADBEEF, 1, 0);
        check("word_stall_cycles", stall_cnt, 3);
        check("word_rdata", rdata, 32'hDEADBEEF);

        do_access(1, 0, 2'b00, 1, 32'h103, 0, 32'h80112233, 0, 0);
        check("sbyte_rdata", rdata, 32'hFFFFFF80);
        do_access(1, 0, 2'b00, 0, 32'h103, 0, 32'h80112233, 0, 0);
        check("ubyte_rdata", rdata, 32'h00000080);

        do_access(0, 1, 2'b01, 0, 32'h0A2, 32'h1234ABCD, 32'h55555555, 0, 0);
        check("hstore_rdata_kept", rdata, 32'h00000080);

        r0 = req_rises;
        stall_cnt = 0;
        do_access(1, 0, 2'b10, 0, 32'h102, 0, 0, 0, 0);
        check("mis_no_req", req_rises - r0, 0);
        check("mis_no_stall", stall_cnt, 0);

        dmem_ack = 1; dmem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        check("idle_ack_req", 32'(dmem_req), 0);
        @(posedge clk); #1;
        dmem_ack = 0;
        check("idle_ack_rdata", rdata, exp_rdata);

        r0 = req_rises;
        do_access(1, 0, 2'b01, 1, 32'h0F0, 0, 32'h0000_8001, 0, 1);
        do_access(1, 0, 2'b01, 1, 32'h0F0, 0, 32'h0000_7FFE, 2, 0);
        check("b2b_req_count", req_rises - r0, 2);

        memread = 1; length = 2'b10; addr = 32'h200;
        @(posedge clk); #1;
        @(negedge clk);
        check("pre_rst_req", 32'(dmem_req), 1);
        @(posedge clk); #1;
        rst = 1;
        #1;
        check("mid_rst_req", 32'(dmem_req), 0);
        check("mid_rst_stall", 32'(stall), 0);
        check("mid_rst_rdata", rdata, 0);
        drop();
        @(posedge clk); #1;
        rst = 0;
        exp_rdata = 0;
        @(posedge clk); #1;
        dmem_ack = 1; dmem_rdata = 32'h12345678;
        @(negedge clk);
        check("late_ack_req", 32'(dmem_req), 0);
        @(posedge clk); #1;
        dmem_ack = 0;
        @(negedge clk);
        check("late_ack_rdata", rdata, 0);
        check("late_ack_stall", 32'(stall), 0);
        @(posedge clk); #1;

        for (int t = 0; t < 60; t++) begin
            bit rd = 1'($urandom);
            bit wr = rd ? 1'($urandom) : 1'b1;
            do_access(rd, wr, 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                      int'($urandom_range(0, 3)), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
